ppu_stream: RTL and testbench

Parametrised, stream-handshaked post-processing unit for accumulator rows leaving the systolic array. Per lane it computes scale × acc + bias, then optional ReLU, a rounding right shift and signed saturation to OUT_W bits, and writes one quantised row per beat to the output RAM. Scale and bias tables are runtime-programmable. A job covers ROWS×TILES beats and ends with a done pulse.

---
 rtl/ppu_stream_if.sv | 16 +
 rtl/ppu_stream.sv | 140 ++++++++++++++
 tb/tb_ppu_stream.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_stream_if.sv
// ppu_stream_if: accumulator-row stream in, quantised-row RAM write port out
interface ppu_stream_if #(
  parameter int LANES = 16,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8,
  parameter int AW    = 6
);
  logic                   acc_valid;
  logic                   acc_ready;
  logic [LANES*ACC_W-1:0] acc_data;
  logic                   ram_we;
  logic [AW-1:0]          ram_addr;
  logic [LANES*OUT_W-1:0] ram_data;
  modport master (output acc_valid, acc_data, input acc_ready, ram_we, ram_addr, ram_data);
  modport slave  (input acc_valid, acc_data, output acc_ready, ram_we, ram_addr, ram_data);
endinterface

// File: rtl/ppu_stream.sv
// ppu_stream: per-lane scale*acc+bias, ReLU, rounding shift and saturation into the output RAM
module ppu_stream #(
  parameter int LANES   = 16,
  parameter int ACC_W   = 24,
  parameter int SCALE_W = 16,
  parameter int BIAS_W  = 16,
  parameter int OUT_W   = 8,
  parameter int ROWS    = 16,
  parameter int TILES   = 4,
  localparam int RW = $clog2(ROWS),
  localparam int AW = $clog2(ROWS*TILES),
  localparam int TW = TILES > 1 ? $clog2(TILES) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cfg_we,
  input  logic                     i_cfg_sel,
  input  logic [RW-1:0]            i_cfg_addr,
  input  logic [LANES*SCALE_W-1:0] i_cfg_data,
  input  logic                     i_start,
  input  logic                     i_relu_en,
  input  logic [5:0]               i_shift,
  output logic                     o_busy,
  ppu_stream_if.slave              bus,
  output logic                     o_sat,
  output logic                     o_done
);
  localparam int PW = SCALE_W + ACC_W;
  localparam int SW = PW + 1;
  localparam int XW = SW + 64;
  localparam logic signed [XW-1:0] MAXV = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                  state;
  logic [RW-1:0]           row_cnt;
  logic [TW-1:0]           tile_cnt;
  logic                    relu_q;
  logic [5:0]              shift_q;
  logic                    ready_q;
  logic                    accept, last_row, last_tile;
  logic signed [SCALE_W-1:0] scale_tab [ROWS][LANES];
  logic signed [BIAS_W-1:0]  bias_tab [ROWS];
  logic signed [SW-1:0]    s1_next [LANES];
  logic signed [SW-1:0]    s1_sum [LANES];
  logic [AW-1:0]           s1_addr;
  logic                    s1_v;
  logic signed [XW-1:0]    rnd;
  logic [LANES-1:0]        clamp;
  logic [LANES*OUT_W-1:0]  q_row;
  logic                    we_q;
  logic [AW-1:0]           addr_q;
  logic [LANES*OUT_W-1:0]  data_q;
  assign accept    = ready_q && bus.acc_valid;
  assign last_row  = row_cnt == RW'(ROWS-1);
  assign last_tile = tile_cnt == TW'(TILES-1);
  assign rnd       = shift_q == 6'd0 ? '0 : XW'(1) << (shift_q - 6'd1);
  assign bus.acc_ready = ready_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_data  = data_q;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [PW-1:0] prod;
    logic signed [XW-1:0] pre, rs;
    assign prod = PW'(scale_tab[row_cnt][l]) * PW'($signed(bus.acc_data[l*ACC_W +: ACC_W]));
    assign s1_next[l] = SW'(prod) + SW'(bias_tab[row_cnt]);
    assign pre = (relu_q && s1_sum[l][SW-1]) ? '0 : XW'(s1_sum[l]);
    assign rs = (pre + rnd) >>> shift_q;
    assign clamp[l] = rs > MAXV || rs < MINV;
    assign q_row[l*OUT_W +: OUT_W] = rs > MAXV ? MAXV[OUT_W-1:0] : rs < MINV ? MINV[OUT_W-1:0] : rs[OUT_W-1:0];
  end
  // tables are plain storage without reset, writable only while idle
  always_ff @(posedge i_clk)
    if (i_cfg_we && state == IDLE) begin
      if (i_cfg_sel) bias_tab[i_cfg_addr] <= i_cfg_data[BIAS_W-1:0];
      else for (int i = 0; i < LANES; i++) scale_tab[i_cfg_addr][i] <= i_cfg_data[i*SCALE_W +: SCALE_W];
    end
  // job sequencing: beat counters, latched job settings, sticky saturation and done pulse
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state    <= IDLE;
      row_cnt  <= '0;
      tile_cnt <= '0;
      relu_q   <= 1'b0;
      shift_q  <= '0;
      ready_q  <= 1'b0;
      o_busy   <= 1'b0;
      o_sat    <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (s1_v && |clamp) o_sat <= 1'b1;
      case (state)
        IDLE: if (i_start && !o_done) begin
          state    <= RUN;
          ready_q  <= 1'b1;
          o_busy   <= 1'b1;
          relu_q   <= i_relu_en;
          shift_q  <= i_shift;
          o_sat    <= 1'b0;
          row_cnt  <= '0;
          tile_cnt <= '0;
        end
        RUN: if (accept) begin
          row_cnt <= last_row ? '0 : row_cnt + RW'(1);
          if (last_row) tile_cnt <= last_tile ? '0 : tile_cnt + TW'(1);
          if (last_row && last_tile) begin
            state   <= DRAIN;
            ready_q <= 1'b0;
          end
        end
        DRAIN: if (!s1_v && !we_q) begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  // two-stage datapath: S1 captures scaled+biased lanes, S2 rounds/saturates into the write port
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      s1_v    <= 1'b0;
      s1_addr <= '0;
      for (int i = 0; i < LANES; i++) s1_sum[i] <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_addr <= AW'(tile_cnt * ROWS + row_cnt);
        for (int i = 0; i < LANES; i++) s1_sum[i] <= s1_next[i];
      end
      we_q <= s1_v;
      if (s1_v) begin
        addr_q <= s1_addr;
        data_q <= q_row;
      end
    end
endmodule

// File: tb/tb_ppu_stream.sv
// tb_ppu_stream: randomized job-level bench for ppu_stream against an arithmetic reference model
module tb_ppu_stream;
  localparam int LANES = 16, ACC_W = 24, SCALE_W = 16, BIAS_W = 16, OUT_W = 8, ROWS = 16, TILES = 4;
  localparam int RW = 4, AW = 6, NB = ROWS * TILES;
  localparam longint MAXV = 127, MINV = -128;
  logic i_clk = 1'b0, i_rst_n, i_cfg_we, i_cfg_sel, i_start, i_relu_en, o_busy, o_sat, o_done;
  logic [RW-1:0] i_cfg_addr;
  logic [LANES*SCALE_W-1:0] i_cfg_data;
  logic [5:0] i_shift;
  ppu_stream_if #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .AW(AW)) bus();
  ppu_stream #(.LANES(LANES), .ACC_W(ACC_W), .SCALE_W(SCALE_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W),
               .ROWS(ROWS), .TILES(TILES)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_we(i_cfg_we), .i_cfg_sel(i_cfg_sel),
    .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data), .i_start(i_start), .i_relu_en(i_relu_en),
    .i_shift(i_shift), .o_busy(o_busy), .bus(bus), .o_sat(o_sat), .o_done(o_done));
  always #5 i_clk = ~i_clk;
  int vectors = 0, errs = 0, cyc = 0;
  int scale_m [ROWS][LANES];
  int bias_m [ROWS];
  logic [LANES*ACC_W-1:0] acc_mem [NB];
  logic [AW-1:0] wq_addr[$];
  logic [LANES*OUT_W-1:0] wq_data[$];
  int n_done, done_nw, done_cyc, last_we_cyc, ready_bad;
  bit done_sat, timed_out, sat0;
  always @(posedge i_clk) cyc++;
  always @(negedge i_clk) begin
    if (bus.ram_we) begin
      wq_addr.push_back(bus.ram_addr);
      wq_data.push_back(bus.ram_data);
      last_we_cyc = cyc;
    end
    if (o_done) begin
      n_done++;
      done_nw = wq_addr.size();
      done_cyc = cyc;
      done_sat = o_sat;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
  function automatic longint q_lane(longint s, longint a, longint b, bit relu, int sh, output bit c);
    longint v, d, q;
    v = s * a + b;
    if (relu && v < 0) v = 0;
    if (sh > 0) begin
      d = longint'(1) << sh;
      v = v + d / 2;
      q = v / d;
      if (v < 0 && q * d != v) q = q - 1;
      v = q;
    end
    c = v > MAXV || v < MINV;
    return v > MAXV ? MAXV : v < MINV ? MINV : v;
  endfunction
  function automatic logic [LANES*OUT_W-1:0] exp_row(int i, bit relu, int sh, output bit sat);
    logic [LANES*OUT_W-1:0] r;
    longint v;
    bit c;
    int row;
    row = i % ROWS;
    sat = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      v = q_lane(longint'(scale_m[row][l]), longint'($signed(acc_mem[i][l*ACC_W +: ACC_W])),
                 longint'(bias_m[row]), relu, sh, c);
      r[l*OUT_W +: OUT_W] = v[OUT_W-1:0];
      sat |= c;
    end
    return r;
  endfunction
  task automatic set_uniform(input int s, input int b);
    for (int r = 0; r < ROWS; r++) begin
      bias_m[r] = b;
      for (int l = 0; l < LANES; l++) scale_m[r][l] = s;
    end
  endtask
  task automatic fill_acc(input int even, input int odd);
    for (int i = 0; i < NB; i++)
      for (int l = 0; l < LANES; l++) acc_mem[i][l*ACC_W +: ACC_W] = ACC_W'(l % 2 == 0 ? even : odd);
  endtask
  task automatic load_tables();
    for (int r = 0; r < ROWS; r++) begin
      @(posedge i_clk); #1;
      i_cfg_we = 1'b1; i_cfg_sel = 1'b0; i_cfg_addr = RW'(r);
      for (int l = 0; l < LANES; l++) i_cfg_data[l*SCALE_W +: SCALE_W] = SCALE_W'(scale_m[r][l]);
      @(posedge i_clk); #1;
      i_cfg_sel = 1'b1; i_cfg_data = '0; i_cfg_data[BIAS_W-1:0] = BIAS_W'(bias_m[r]);
    end
    @(posedge i_clk); #1;
    i_cfg_we = 1'b0;
  endtask
  task automatic run_job(input bit relu, input int sh, input int gap, input bit noise, input int abort);
    int beat, guard;
    bit v, take;
    wq_addr.delete(); wq_data.delete();
    n_done = 0; done_nw = -1; ready_bad = 0; timed_out = 1'b0; done_cyc = 0; last_we_cyc = 0;
    @(posedge i_clk); #1;
    i_start = 1'b1; i_relu_en = relu; i_shift = 6'(sh);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    beat = 0; guard = 0;
    while (beat < NB && guard < 4000) begin
      v = $urandom_range(0, 99) >= gap;
      bus.acc_valid = v;
      bus.acc_data = acc_mem[beat];
      if (noise) begin
        i_cfg_we = 1'($urandom); i_cfg_sel = 1'($urandom); i_cfg_addr = RW'($urandom);
        i_cfg_data = {LANES{SCALE_W'($urandom)}};
      end
      @(negedge i_clk);
      if (guard == 0) sat0 = o_sat;
      if (beat == abort) begin
        i_rst_n = 1'b0;
        break;
      end
      take = v && bus.acc_ready;
      @(posedge i_clk); #1;
      if (take) beat++;
      guard++;
    end
    bus.acc_valid = 1'b0;
    i_cfg_we = 1'b0;
    if (abort < 0) begin
      if (beat < NB) timed_out = 1'b1;
      for (int k = 0; k < 20 && n_done == 0 && !timed_out; k++) begin
        @(negedge i_clk);
        if (bus.acc_ready) ready_bad++;
        @(posedge i_clk); #1;
      end
      if (n_done == 0) timed_out = 1'b1;
      repeat (2) begin
        @(negedge i_clk);
        if (bus.acc_ready) ready_bad++;
      end
    end
  endtask
  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    vectors++;
    if ({o_busy, bus.acc_ready, bus.ram_we, o_sat, o_done} !== 5'b0) begin
      errs++; $display("FAIL reset_flags: got %b want 00000", {o_busy, bus.acc_ready, bus.ram_we, o_sat, o_done});
    end
    vectors++;
    if (bus.ram_addr !== '0) begin errs++; $display("FAIL reset_addr: got %0d want 0", bus.ram_addr); end
    vectors++;
    if (bus.ram_data !== '0) begin errs++; $display("FAIL reset_data: got %h want 0", bus.ram_data); end
  endtask
  task automatic test_identity();
    logic [LANES*OUT_W-1:0] e;
    bit c, es;
    set_uniform(1024, 0);
    load_tables();
    fill_acc(5, 5);
    run_job(1'b0, 10, 0, 1'b0, -1);
    es = 1'b0;
    vectors++;
    if (wq_addr.size() !== NB) begin errs++; $display("FAIL identity_count: got %0d want %0d", wq_addr.size(), NB); end
    for (int i = 0; i < NB; i++) begin
      e = exp_row(i, 1'b0, 10, c);
      es |= c;
      if (i < wq_addr.size()) begin
        vectors += 2;
        if (wq_addr[i] !== AW'(i)) begin errs++; $display("FAIL identity_addr[%0d]: got %0d want %0d", i, wq_addr[i], i); end
        if (wq_data[i] !== e) begin errs++; $display("FAIL identity_data[%0d]: got %h want %h", i, wq_data[i], e); end
      end
    end
    vectors++;
    if (wq_data.size() > 0 && wq_data[0] !== {LANES{8'd5}}) begin errs++; $display("FAIL identity_const: got %h want all 05", wq_data[0]); end
    vectors++;
    if (n_done !== 1 || timed_out) begin errs++; $display("FAIL identity_done: got %0d pulses (timeout %0b) want 1", n_done, timed_out); end
    vectors++;
    if (done_nw !== NB) begin errs++; $display("FAIL identity_done_order: got %0d writes before done want %0d", done_nw, NB); end
    vectors++;
    if (done_cyc - last_we_cyc < 1 || done_cyc - last_we_cyc > 3) begin
      errs++; $display("FAIL identity_done_gap: got %0d cycles want 1..3", done_cyc - last_we_cyc);
    end
    vectors++;
    if (done_sat !== es) begin errs++; $display("FAIL identity_sat: got %0b want %0b", done_sat, es); end
    vectors++;
    if (ready_bad !== 0) begin errs++; $display("FAIL identity_ready_drain: got %0d high cycles want 0", ready_bad); end
  endtask
  task automatic test_bias_relu();
    logic [LANES*OUT_W-1:0] e;
    bit c, es;
    set_uniform(1024, 0);
    bias_m[3] = -2048;
    load_tables();
    fill_acc(1, 1);
    for (int relu = 0; relu < 2; relu++) begin
      run_job(1'(relu), 10, 0, 1'b0, -1);
      es = 1'b0;
      vectors++;
      if (wq_addr.size() !== NB || n_done !== 1) begin
        errs++; $display("FAIL bias_relu%0d_count: got %0d writes %0d done want %0d 1", relu, wq_addr.size(), n_done, NB);
      end
      for (int i = 0; i < NB; i++) begin
        e = exp_row(i, 1'(relu), 10, c);
        es |= c;
        if (i < wq_addr.size()) begin
          vectors += 2;
          if (wq_addr[i] !== AW'(i)) begin errs++; $display("FAIL bias_relu%0d_addr[%0d]: got %0d want %0d", relu, i, wq_addr[i], i); end
          if (wq_data[i] !== e) begin errs++; $display("FAIL bias_relu%0d_data[%0d]: got %h want %h", relu, i, wq_data[i], e); end
        end
      end
      for (int t = 0; t < TILES; t++)
        if (wq_data.size() == NB) begin
          vectors++;
          if (wq_data[t*ROWS+3][7:0] !== (relu != 0 ? 8'h00 : 8'hff))
            begin errs++; $display("FAIL bias_relu%0d_row3_t%0d: got %h want %h", relu, t, wq_data[t*ROWS+3][7:0], relu != 0 ? 8'h00 : 8'hff); end
        end
      vectors++;
      if (done_sat !== es) begin errs++; $display("FAIL bias_relu%0d_sat: got %0b want %0b", relu, done_sat, es); end
    end
  endtask
  task automatic test_saturation();
    logic [LANES*OUT_W-1:0] e, k_row;
    bit c, es;
    int av;
    set_uniform(1024, 0);
    load_tables();
    for (int k = 0; k < 3; k++) begin
      av = k == 0 ? 1000 : k == 1 ? -1000 : 5;
      k_row = k == 0 ? {LANES{8'h7f}} : k == 1 ? {LANES{8'h80}} : {LANES{8'h05}};
      fill_acc(av, av);
      run_job(1'b0, 10, 0, 1'b0, -1);
      es = 1'b0;
      vectors++;
      if (wq_addr.size() !== NB || n_done !== 1) begin
        errs++; $display("FAIL sat%0d_count: got %0d writes %0d done want %0d 1", k, wq_addr.size(), n_done, NB);
      end
      for (int i = 0; i < NB; i++) begin
        e = exp_row(i, 1'b0, 10, c);
        es |= c;
        if (i < wq_addr.size()) begin
          vectors += 2;
          if (wq_addr[i] !== AW'(i)) begin errs++; $display("FAIL sat%0d_addr[%0d]: got %0d want %0d", k, i, wq_addr[i], i); end
          if (wq_data[i] !== e) begin errs++; $display("FAIL sat%0d_data[%0d]: got %h want %h", k, i, wq_data[i], e); end
        end
      end
      vectors++;
      if (wq_data.size() > 0 && wq_data[0] !== k_row) begin errs++; $display("FAIL sat%0d_const: got %h want %h", k, wq_data[0], k_row); end
      vectors++;
      if (done_sat !== es) begin errs++; $display("FAIL sat%0d_flag: got %0b want %0b", k, done_sat, es); end
      if (k == 2) begin
        vectors++;
        if (sat0 !== 1'b0) begin errs++; $display("FAIL sat_clear_on_start: got %0b want 0", sat0); end
      end
    end
  endtask
  task automatic test_rounding();
    logic [LANES*OUT_W-1:0] e;
    bit c, es;
    int sh;
    set_uniform(1, 0);
    load_tables();
    fill_acc(3, -3);
    for (int k = 0; k < 2; k++) begin
      sh = 1 - k;
      run_job(1'b0, sh, 0, 1'b0, -1);
      es = 1'b0;
      vectors++;
      if (wq_addr.size() !== NB || n_done !== 1) begin
        errs++; $display("FAIL round_sh%0d_count: got %0d writes %0d done want %0d 1", sh, wq_addr.size(), n_done, NB);
      end
      for (int i = 0; i < NB; i++) begin
        e = exp_row(i, 1'b0, sh, c);
        es |= c;
        if (i < wq_addr.size()) begin
          vectors += 2;
          if (wq_addr[i] !== AW'(i)) begin errs++; $display("FAIL round_sh%0d_addr[%0d]: got %0d want %0d", sh, i, wq_addr[i], i); end
          if (wq_data[i] !== e) begin errs++; $display("FAIL round_sh%0d_data[%0d]: got %h want %h", sh, i, wq_data[i], e); end
        end
      end
      vectors++;
      if (wq_data.size() > 0 && wq_data[0][15:0] !== (sh == 1 ? 16'hff02 : 16'hfd03))
        begin errs++; $display("FAIL round_sh%0d_const: got %h want %h", sh, wq_data[0][15:0], sh == 1 ? 16'hff02 : 16'hfd03); end
      vectors++;
      if (done_sat !== es) begin errs++; $display("FAIL round_sh%0d_sat: got %0b want %0b", sh, done_sat, es); end
    end
  endtask
  task automatic test_backpressure();
    logic [LANES*OUT_W-1:0] e;
    bit c, es, relu;
    int sh;
    for (int r = 0; r < ROWS; r++) begin
      bias_m[r] = int'($urandom_range(0, 65535)) - 32768;
      for (int l = 0; l < LANES; l++) scale_m[r][l] = int'($urandom_range(0, 4095)) - 2048;
    end
    load_tables();
    for (int i = 0; i < NB; i++)
      for (int l = 0; l < LANES; l++) acc_mem[i][l*ACC_W +: ACC_W] = ACC_W'(int'($urandom_range(0, 2047)) - 1024);
    for (int j = 0; j < 2; j++) begin
      relu = 1'($urandom);
      sh = int'($urandom_range(10, 14));
      run_job(relu, sh, 40, 1'b1, -1);
      es = 1'b0;
      vectors++;
      if (wq_addr.size() !== NB || n_done !== 1 || timed_out) begin
        errs++; $display("FAIL bp%0d_count: got %0d writes %0d done want %0d 1", j, wq_addr.size(), n_done, NB);
      end
      for (int i = 0; i < NB; i++) begin
        e = exp_row(i, relu, sh, c);
        es |= c;
        if (i < wq_addr.size()) begin
          vectors += 2;
          if (wq_addr[i] !== AW'(i)) begin errs++; $display("FAIL bp%0d_addr[%0d]: got %0d want %0d", j, i, wq_addr[i], i); end
          if (wq_data[i] !== e) begin errs++; $display("FAIL bp%0d_data[%0d]: got %h want %h", j, i, wq_data[i], e); end
        end
      end
      vectors++;
      if (done_sat !== es) begin errs++; $display("FAIL bp%0d_sat: got %0b want %0b", j, done_sat, es); end
      vectors++;
      if (ready_bad !== 0) begin errs++; $display("FAIL bp%0d_ready_idle: got %0d high cycles want 0", j, ready_bad); end
    end
  endtask
  task automatic test_reset_midjob();
    logic [LANES*OUT_W-1:0] e;
    bit c, es;
    int nw0;
    run_job(1'b0, 12, 20, 1'b0, 20);
    @(posedge i_clk);
    @(negedge i_clk);
    nw0 = wq_addr.size();
    vectors++;
    if ({o_busy, bus.acc_ready, bus.ram_we, o_sat, o_done} !== 5'b0) begin
      errs++; $display("FAIL midreset_flags: got %b want 00000", {o_busy, bus.acc_ready, bus.ram_we, o_sat, o_done});
    end
    vectors++;
    if (bus.ram_addr !== '0 || bus.ram_data !== '0) begin
      errs++; $display("FAIL midreset_outputs: got addr %0d data %h want 0 0", bus.ram_addr, bus.ram_data);
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (6) @(negedge i_clk);
    vectors++;
    if (wq_addr.size() !== nw0 || n_done !== 0) begin
      errs++; $display("FAIL midreset_quiet: got %0d extra writes %0d done want 0 0", wq_addr.size() - nw0, n_done);
    end
    run_job(1'b1, 11, 25, 1'b0, -1);
    es = 1'b0;
    vectors++;
    if (wq_addr.size() !== NB || n_done !== 1 || timed_out) begin
      errs++; $display("FAIL midreset_rerun_count: got %0d writes %0d done want %0d 1", wq_addr.size(), n_done, NB);
    end
    for (int i = 0; i < NB; i++) begin
      e = exp_row(i, 1'b1, 11, c);
      es |= c;
      if (i < wq_addr.size()) begin
        vectors += 2;
        if (wq_addr[i] !== AW'(i)) begin errs++; $display("FAIL midreset_rerun_addr[%0d]: got %0d want %0d", i, wq_addr[i], i); end
        if (wq_data[i] !== e) begin errs++; $display("FAIL midreset_rerun_data[%0d]: got %h want %h", i, wq_data[i], e); end
      end
    end
    vectors++;
    if (done_sat !== es) begin errs++; $display("FAIL midreset_rerun_sat: got %0b want %0b", done_sat, es); end
  endtask
  initial begin
    i_rst_n = 1'b0; i_cfg_we = 1'b0; i_cfg_sel = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
    i_start = 1'b0; i_relu_en = 1'b0; i_shift = '0; bus.acc_valid = 1'b0; bus.acc_data = '0;
    test_reset();
    test_identity();
    test_bias_relu();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_reset_midjob();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
